l1_bus_arbiter: RTL and testbench

//  Shares the single L1 cache bus unit between the L1-I and L1-D cache controllers.

---
 rtl/l1_bus_arbiter.sv | 170 +++++++++++++++++
 tb/tb_l1_bus_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_bus_arbiter.sv
// Round-robin arbiter sharing cache_bus_unit between the L1-I and L1-D controllers.
// Optional grant watchdog is enabled by defining L1_ARB_TIMEOUT_EN.
module l1_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        i_wt_req,
    input  logic        i_rd_req,
    input  logic        i_line_req,
    input  logic [3:0]  i_size,
    input  logic [63:0] i_pa,
    input  logic [63:0] i_wt_data,
    output logic [63:0] i_line_data,
    output logic [10:0] i_addr_count,
    output logic        i_line_write,
    output logic        i_entry_write,
    output logic        i_trans_rdy,
    output logic        i_bus_error,

    input  logic        d_wt_req,
    input  logic        d_rd_req,
    input  logic        d_line_req,
    input  logic [3:0]  d_size,
    input  logic [63:0] d_pa,
    input  logic [63:0] d_wt_data,
    output logic [63:0] d_line_data,
    output logic [10:0] d_addr_count,
    output logic        d_line_write,
    output logic        d_entry_write,
    output logic        d_trans_rdy,
    output logic        d_bus_error,

    output logic        bu_wt_req,
    output logic        bu_rd_req,
    output logic        bu_line_req,
    output logic [3:0]  bu_size,
    output logic [63:0] bu_pa,
    output logic [63:0] bu_wt_data,
    input  logic [63:0] bu_line_data,
    input  logic [10:0] bu_addr_count,
    input  logic        bu_line_write,
    input  logic        bu_entry_write,
    input  logic        bu_trans_rdy,
    input  logic        bu_bus_error,

    output logic        grant_i,
    output logic        grant_d,
    output logic        timeout_flag,
    output logic [1:0]  dbg_state_o
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GRANT_I = 2'd1;
    localparam logic [1:0] S_GRANT_D = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    logic [1:0] state_q, state_d;
    logic       last_d_q, last_d_d;
    logic       req_i, req_d;
    logic       gnt_i, gnt_d;
    logic       tmo_fire;
    logic       done;

    // Handshake: a requester raises one of wt/rd/line and holds it with its fields stable
    // until it sees trans_rdy or bus_error; the grant is never revoked before that.
    assign req_i = i_wt_req | i_rd_req | i_line_req;
    assign req_d = d_wt_req | d_rd_req | d_line_req;
    assign gnt_i = (state_q == S_GRANT_I);
    assign gnt_d = (state_q == S_GRANT_D);
    assign done  = (gnt_i | gnt_d) & (bu_trans_rdy | bu_bus_error | tmo_fire);

`ifdef L1_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_IDLE) begin
            cnt_d = '0;
        end else if (gnt_i | gnt_d) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // A real completion in the same cycle wins over the watchdog.
    assign tmo_fire = (gnt_i | gnt_d) & ~bu_trans_rdy & ~bu_bus_error &
                      (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYCLES != 0) ^ (CNT_W != 0);
    assign tmo_fire   = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        case (state_q)
            S_IDLE: begin
                if (req_i && req_d) begin
                    state_d = last_d_q ? S_GRANT_I : S_GRANT_D;
                end else if (req_i) begin
                    state_d = S_GRANT_I;
                end else if (req_d) begin
                    state_d = S_GRANT_D;
                end
            end
            S_GRANT_I: begin
                if (done) begin
                    state_d  = S_RELEASE;
                    last_d_d = 1'b0;
                end
            end
            S_GRANT_D: begin
                if (done) begin
                    state_d  = S_RELEASE;
                    last_d_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            last_d_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
        end
    end

    // Downstream request path: owner's fields only, requests killed on a watchdog hit.
    assign bu_wt_req   = ~tmo_fire & ((gnt_i & i_wt_req)   | (gnt_d & d_wt_req));
    assign bu_rd_req   = ~tmo_fire & ((gnt_i & i_rd_req)   | (gnt_d & d_rd_req));
    assign bu_line_req = ~tmo_fire & ((gnt_i & i_line_req) | (gnt_d & d_line_req));
    assign bu_size     = ({4{gnt_i}} & i_size)     | ({4{gnt_d}} & d_size);
    assign bu_pa       = ({64{gnt_i}} & i_pa)      | ({64{gnt_d}} & d_pa);
    assign bu_wt_data  = ({64{gnt_i}} & i_wt_data) | ({64{gnt_d}} & d_wt_data);

    assign i_line_data   = {64{gnt_i}} & bu_line_data;
    assign i_addr_count  = {11{gnt_i}} & bu_addr_count;
    assign i_line_write  = gnt_i & bu_line_write;
    assign i_entry_write = gnt_i & bu_entry_write;
    assign i_trans_rdy   = gnt_i & bu_trans_rdy;
    assign i_bus_error   = gnt_i & (bu_bus_error | tmo_fire);

    assign d_line_data   = {64{gnt_d}} & bu_line_data;
    assign d_addr_count  = {11{gnt_d}} & bu_addr_count;
    assign d_line_write  = gnt_d & bu_line_write;
    assign d_entry_write = gnt_d & bu_entry_write;
    assign d_trans_rdy   = gnt_d & bu_trans_rdy;
    assign d_bus_error   = gnt_d & (bu_bus_error | tmo_fire);

    assign grant_i      = gnt_i;
    assign grant_d      = gnt_d;
    assign timeout_flag = tmo_fire;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_l1_bus_arbiter.sv
// Randomized scoreboard bench for l1_bus_arbiter; honours L1_ARB_TIMEOUT_EN when defined.
module tb_l1_bus_arbiter;
  localparam int TB_TIMEOUT = 64;
  localparam logic [2:0] K_WT = 3'b100;
  localparam logic [2:0] K_RD = 3'b010;
  localparam logic [2:0] K_LINE = 3'b001;

  typedef struct packed {
    logic        side;   // 0 = I, 1 = D
    logic [2:0]  kind;   // {wt, rd, line}
    logic [3:0]  size;
    logic [63:0] pa;
    logic [63:0] wd;
    int          start;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic i_wt_req, i_rd_req, i_line_req, d_wt_req, d_rd_req, d_line_req;
  logic [3:0] i_size, d_size, bu_size;
  logic [63:0] i_pa, i_wt_data, d_pa, d_wt_data, bu_pa, bu_wt_data;
  logic [63:0] i_line_data, d_line_data, bu_line_data;
  logic [10:0] i_addr_count, d_addr_count, bu_addr_count;
  logic i_line_write, i_entry_write, i_trans_rdy, i_bus_error;
  logic d_line_write, d_entry_write, d_trans_rdy, d_bus_error;
  logic bu_wt_req, bu_rd_req, bu_line_req;
  logic bu_line_write, bu_entry_write, bu_trans_rdy, bu_bus_error;
  logic grant_i, grant_d, timeout_flag;
  logic [1:0] dbg_state;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  int m_last = 0;          // model: last owner, 0 = I, 1 = D
  bit tb_done = 0;
  bit rep_ready = 0;
  exp_t exp_q[$];

  logic [2:0]  f_kind [0:1];
  logic [3:0]  f_size [0:1];
  logic [63:0] f_pa   [0:1];
  logic [63:0] f_wd   [0:1];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  l1_bus_arbiter #(.TIMEOUT_CYCLES(TB_TIMEOUT), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_wt_req(i_wt_req), .i_rd_req(i_rd_req), .i_line_req(i_line_req),
    .i_size(i_size), .i_pa(i_pa), .i_wt_data(i_wt_data),
    .i_line_data(i_line_data), .i_addr_count(i_addr_count),
    .i_line_write(i_line_write), .i_entry_write(i_entry_write),
    .i_trans_rdy(i_trans_rdy), .i_bus_error(i_bus_error),
    .d_wt_req(d_wt_req), .d_rd_req(d_rd_req), .d_line_req(d_line_req),
    .d_size(d_size), .d_pa(d_pa), .d_wt_data(d_wt_data),
    .d_line_data(d_line_data), .d_addr_count(d_addr_count),
    .d_line_write(d_line_write), .d_entry_write(d_entry_write),
    .d_trans_rdy(d_trans_rdy), .d_bus_error(d_bus_error),
    .bu_wt_req(bu_wt_req), .bu_rd_req(bu_rd_req), .bu_line_req(bu_line_req),
    .bu_size(bu_size), .bu_pa(bu_pa), .bu_wt_data(bu_wt_data),
    .bu_line_data(bu_line_data), .bu_addr_count(bu_addr_count),
    .bu_line_write(bu_line_write), .bu_entry_write(bu_entry_write),
    .bu_trans_rdy(bu_trans_rdy), .bu_bus_error(bu_bus_error),
    .grant_i(grant_i), .grant_d(grant_d), .timeout_flag(timeout_flag),
    .dbg_state_o(dbg_state)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_side(input int s);
    f_kind[s] = 3'b001 << $urandom_range(0, 2);
    f_size[s] = 4'b0001 << $urandom_range(0, 3);
    f_pa[s]   = {$urandom, $urandom};
    f_wd[s]   = {$urandom, $urandom};
  endtask

  task automatic drive_req(input int s, input bit on);
    logic [2:0] k;
    k = on ? f_kind[s] : 3'b000;
    if (s == 0) begin
      {i_wt_req, i_rd_req, i_line_req} = k;
      i_size = on ? f_size[s] : 4'h0;
      i_pa = on ? f_pa[s] : 64'h0;
      i_wt_data = on ? f_wd[s] : 64'h0;
    end else begin
      {d_wt_req, d_rd_req, d_line_req} = k;
      d_size = on ? f_size[s] : 4'h0;
      d_pa = on ? f_pa[s] : 64'h0;
      d_wt_data = on ? f_wd[s] : 64'h0;
    end
  endtask

  task automatic bus_idle();
    bu_line_data = {$urandom, $urandom};
    bu_addr_count = 11'($urandom);
    {bu_line_write, bu_entry_write, bu_trans_rdy, bu_bus_error} = 4'b0000;
  endtask

  task automatic bus_noise();
    bu_line_data = {$urandom, $urandom};
    bu_addr_count = 11'($urandom);
    {bu_line_write, bu_entry_write, bu_trans_rdy, bu_bus_error} = 4'($urandom);
  endtask

  task automatic push_exp(input int s, input int start);
    exp_t e;
    e.side = (s == 1);
    e.kind = f_kind[s];
    e.size = f_size[s];
    e.pa = f_pa[s];
    e.wd = f_wd[s];
    e.start = start;
    exp_q.push_back(e);
  endtask

  // Acts as cache_bus_unit for one transaction of side s; lat 0 = random, emode 0 random / 1 err+rdy / 2 rdy.
  task automatic serve(input int s, input int start, input int lat, input int emode, output int done);
    int l, done_at, r;
    bit tmo, er, rd;
    l = (lat == 0) ? int'($urandom_range(1, 5)) : lat;
    tmo = 0;
    push_exp(s, start);
    while (cyc < start) begin tick(); bus_idle(); end
    bus_idle();
    if (f_kind[s] == K_LINE) begin
      for (int k = 0; k < 8; k++) begin
        tick();
        bu_line_data = {$urandom, $urandom};
        bu_addr_count = 11'(k);
        bu_line_write = 1'b1;
      end
      done_at = cyc + 1;
    end else begin
      done_at = start + l;
`ifdef L1_ARB_TIMEOUT_EN
      if (l >= TB_TIMEOUT) begin
        done_at = start + TB_TIMEOUT - 1;
        tmo = 1;
      end
`endif
    end
    while (cyc < done_at) begin tick(); bus_idle(); end
    if (!tmo) begin
      r = int'($urandom_range(0, 7));
      er = (emode == 1) || (emode == 0 && r < 2);
      rd = (emode != 0) || (r != 0);
      bu_trans_rdy = rd;
      bu_bus_error = er;
      bu_entry_write = rd && (f_kind[s] == K_LINE);
    end
    done = cyc;
    tick();
    drive_req(s, 0);
    bus_noise();
    if (tmo) bu_trans_rdy = 1'b1;
    m_last = s;
  endtask

  // mask bit0 = I requests, bit1 = D requests, both raised in the same cycle.
  task automatic do_round(input int mask, input int lat, input int emode);
    int first, second, done, t;
    bus_idle();
    if (mask[0]) drive_req(0, 1);
    if (mask[1]) drive_req(1, 1);
    t = cyc;
    second = -1;
    if (mask == 3) begin
      first = (m_last == 0) ? 1 : 0;
      second = 1 - first;
    end else begin
      first = (mask == 1) ? 0 : 1;
    end
    serve(first, t + 1, lat, emode, done);
    if (second >= 0) serve(second, done + 3, lat, emode, done);
    repeat ($urandom_range(1, 3)) begin tick(); bus_noise(); end
  endtask

  task automatic reset_mid_line();
    int t;
    randomize_side(1);
    f_kind[1] = K_LINE;
    bus_idle();
    drive_req(1, 1);
    t = cyc;
    push_exp(1, t + 1);
    tick();
    bus_idle();
    for (int k = 0; k < 3; k++) begin
      tick();
      bu_addr_count = 11'(k);
      bu_line_write = 1'b1;
    end
    tick();
    rst_n = 1'b0;
    drive_req(0, 0);
    drive_req(1, 0);
    bus_noise();
    repeat (2) begin tick(); bus_noise(); end
    rst_n = 1'b1;
    m_last = 0;
    bus_idle();
    tick();
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: actual %h required %h", name, cyc, act, exp);
  endtask

  initial begin
    exp_t cur;
    bit busy, tmo;
    int gcnt;
    logic [78:0] act_i, act_d, side_v, exp_i, exp_d;
    logic [2:0] bu_req;
    busy = 0;
    gcnt = 0;
    cur = '0;
    forever begin
      @(negedge clk);
      act_i = {i_line_data, i_addr_count, i_line_write, i_entry_write, i_trans_rdy, i_bus_error};
      act_d = {d_line_data, d_addr_count, d_line_write, d_entry_write, d_trans_rdy, d_bus_error};
      bu_req = {bu_wt_req, bu_rd_req, bu_line_req};
      if (!rst_n) begin
        check("reset_outputs", 256'({act_i, act_d, grant_i, grant_d, timeout_flag, bu_req}), 256'(0));
        busy = 0;
        exp_q.delete();
      end else begin
        if (!busy && (grant_i || grant_d || (|bu_req))) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            $display("FAIL unexpected_grant @cyc %0d: actual grant_i=%0b grant_d=%0b bu_req=%b required no grant",
                     cyc, grant_i, grant_d, bu_req);
          end else begin
            n_pass++;
            cur = exp_q.pop_front();
            busy = 1;
            gcnt = 0;
            check("start_cycle", 256'(cyc), 256'(cur.start));
          end
        end
        if (busy) begin
          gcnt++;
          tmo = 0;
`ifdef L1_ARB_TIMEOUT_EN
          tmo = (gcnt == TB_TIMEOUT) && !bu_trans_rdy && !bu_bus_error;
`endif
          side_v = {bu_line_data, bu_addr_count, bu_line_write, bu_entry_write, bu_trans_rdy, bu_bus_error | tmo};
          exp_i = cur.side ? 79'h0 : side_v;
          exp_d = cur.side ? side_v : 79'h0;
          check("side_outputs", 256'({act_i, act_d, grant_i, grant_d, timeout_flag}),
                256'({exp_i, exp_d, !cur.side, cur.side, tmo}));
          check("bu_fields", 256'({bu_req, bu_size, bu_pa, bu_wt_data}),
                256'({tmo ? 3'b000 : cur.kind, cur.size, cur.pa, cur.wd}));
          if (bu_trans_rdy || bu_bus_error || tmo) busy = 0;
        end else begin
          check("idle_outputs", 256'({act_i, act_d, grant_i, grant_d, timeout_flag, bu_req}), 256'(0));
        end
      end
      if (tb_done && !rep_ready) begin
        check("queue_drained", 256'(exp_q.size()), 256'(0));
        check("no_open_grant", 256'(busy), 256'(0));
        rep_ready = 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      randomize_side(s);
      drive_req(s, 0);
    end
    bus_idle();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // ties after reset: D first, then I; next tie goes to D again
    randomize_side(0); randomize_side(1);
    do_round(3, 0, 2);
    randomize_side(0); randomize_side(1);
    do_round(3, 0, 0);

    // single I read at a fixed address, completion 4 cycles after grant
    randomize_side(0);
    f_kind[0] = K_RD;
    f_pa[0] = 64'h0000_0000_8000_0010;
    do_round(1, 4, 2);

    // D line read with beat counter 0..7
    randomize_side(1);
    f_kind[1] = K_LINE;
    do_round(2, 0, 2);

    // I completion with error and ready together
    randomize_side(0);
    f_kind[0] = K_RD;
    do_round(1, 2, 1);

    // D write-through stalled for 100 cycles
    randomize_side(1);
    f_kind[1] = K_WT;
    do_round(2, 100, 2);

    // reset in the middle of a D line read, then an I request and a fresh tie
    reset_mid_line();
    randomize_side(0);
    do_round(1, 0, 0);
    randomize_side(0); randomize_side(1);
    do_round(3, 0, 0);

    for (int r = 0; r < 40; r++) begin
      randomize_side(0);
      randomize_side(1);
      do_round(int'($urandom_range(1, 3)), 0, 0);
    end

    tb_done = 1;
    for (int w = 0; w < 10 && !rep_ready; w++) tick();
    if (!rep_ready) $display("FAIL final_report: actual monitor idle required monitor report");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
